// File: rtl/decode_stage.sv
// IF/ID decode stage for the pipelined MIPS datapath: turns one instruction per cycle into
// registered ID/EX control fields, with load-use bubbles, flush handling and a sticky HALT.
package decode_pkg;
    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW    = 6'h2b,
                           OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SLLV = 6'h04,
                           FN_SRLV = 6'h06, FN_JR  = 6'h08, FN_ADD  = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                           FN_AND  = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26,
                           FN_NOR  = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
endpackage

module decode_stage import decode_pkg::*; #(
    parameter int WORD_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int HAZARD_EN = 1,
    parameter int LINK_REG  = 31
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic [31:0]          instr,
    input  logic [WORD_W-1:0]    npc,
    input  logic                 flush,
    input  logic                 ex_dren,
    input  logic [RF_ADDR_W-1:0] ex_wsel,
    output logic                 hazard_stall,
    output logic                 id_valid,
    output logic [RF_ADDR_W-1:0] id_rs,
    output logic [RF_ADDR_W-1:0] id_rt,
    output logic [RF_ADDR_W-1:0] id_wsel,
    output logic [4:0]           id_shamt,
    output logic [WORD_W-1:0]    id_imm,
    output logic [25:0]          id_jaddr,
    output logic [WORD_W-1:0]    id_npc,
    output aluop_t               id_aluop,
    output logic [1:0]           id_alusrc,
    output logic [2:0]           id_pcsrc,
    output logic [1:0]           id_regsrc,
    output logic                 id_regwrite,
    output logic                 id_dren,
    output logic                 id_dwen,
    output logic                 id_halt
);

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rs;
        logic [RF_ADDR_W-1:0] rt;
        logic [RF_ADDR_W-1:0] wsel;
        logic [4:0]           shamt;
        logic [WORD_W-1:0]    imm;
        logic [25:0]          jaddr;
        logic [WORD_W-1:0]    npc;
        aluop_t               aluop;
        logic [1:0]           alusrc;
        logic [2:0]           pcsrc;
        logic [1:0]           regsrc;
        logic                 regwrite;
        logic                 dren;
        logic                 dwen;
    } id_fields_t;

    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic [RF_ADDR_W-1:0] rs_f;
    logic [RF_ADDR_W-1:0] rt_f;
    logic [RF_ADDR_W-1:0] rd_f;
    logic                 uses_rt;
    logic                 is_halt;
    id_fields_t           dec;
    id_fields_t           id_q;
    logic                 halt_q;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs_f   = RF_ADDR_W'(instr[25:21]);
    assign rt_f   = RF_ADDR_W'(instr[20:16]);
    assign rd_f   = RF_ADDR_W'(instr[15:11]);

    always_comb begin
        dec          = '0;
        uses_rt      = 1'b0;
        is_halt      = 1'b0;
        dec.valid    = 1'b1;
        dec.rs       = rs_f;
        dec.rt       = rt_f;
        dec.wsel     = rt_f;
        dec.shamt    = instr[10:6];
        dec.imm      = WORD_W'($signed(instr[15:0]));
        dec.jaddr    = instr[25:0];
        dec.npc      = npc;
        unique case (opcode)
            OP_RTYPE: begin
                uses_rt      = 1'b1;
                dec.wsel     = rd_f;
                dec.regwrite = 1'b1;
                case (funct)
                    FN_SLL:           begin dec.aluop = ALU_SLL; dec.alusrc = 2'd1; end
                    FN_SRL:           begin dec.aluop = ALU_SRL; dec.alusrc = 2'd1; end
                    FN_SLLV:          dec.aluop = ALU_SLL;
                    FN_SRLV:          dec.aluop = ALU_SRL;
                    FN_ADD, FN_ADDU:  dec.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU:  dec.aluop = ALU_SUB;
                    FN_AND:           dec.aluop = ALU_AND;
                    FN_OR:            dec.aluop = ALU_OR;
                    FN_XOR:           dec.aluop = ALU_XOR;
                    FN_NOR:           dec.aluop = ALU_NOR;
                    FN_SLT:           dec.aluop = ALU_SLT;
                    FN_SLTU:          dec.aluop = ALU_SLTU;
                    FN_JR:            begin dec.regwrite = 1'b0; dec.pcsrc = 3'd2; end
                    default: begin
                        // Unrecognised funct issues as a harmless valid no-op.
                        dec       = '0;
                        dec.valid = 1'b1;
                        dec.npc   = npc;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin dec.aluop = ALU_ADD;  dec.alusrc = 2'd2; dec.regwrite = 1'b1; end
            OP_SLTI:           begin dec.aluop = ALU_SLT;  dec.alusrc = 2'd2; dec.regwrite = 1'b1; end
            OP_SLTIU:          begin dec.aluop = ALU_SLTU; dec.alusrc = 2'd2; dec.regwrite = 1'b1; end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.imm      = WORD_W'(instr[15:0]);
                dec.aluop    = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_XOR;
                dec.alusrc   = 2'd2;
                dec.regwrite = 1'b1;
            end
            OP_LUI: begin
                dec.imm      = WORD_W'({instr[15:0], 16'h0000});
                dec.regsrc   = 2'd1;
                dec.regwrite = 1'b1;
            end
            OP_LW: begin
                dec.aluop    = ALU_ADD;
                dec.alusrc   = 2'd2;
                dec.regsrc   = 2'd2;
                dec.regwrite = 1'b1;
                dec.dren     = 1'b1;
            end
            OP_SW:  begin uses_rt = 1'b1; dec.aluop = ALU_ADD; dec.alusrc = 2'd2; dec.dwen = 1'b1; end
            OP_BEQ: begin uses_rt = 1'b1; dec.aluop = ALU_SUB; dec.pcsrc = 3'd5; end
            OP_BNE: begin uses_rt = 1'b1; dec.aluop = ALU_SUB; dec.pcsrc = 3'd4; end
            OP_J:   dec.pcsrc = 3'd3;
            OP_JAL: begin
                dec.pcsrc    = 3'd3;
                dec.regsrc   = 2'd3;
                dec.regwrite = 1'b1;
                dec.wsel     = RF_ADDR_W'(LINK_REG);
            end
            OP_HALT: is_halt = 1'b1;
            default: begin
                dec       = '0;
                dec.valid = 1'b1;
                dec.npc   = npc;
            end
        endcase
        // $0 is hardwired, so a write there must never reach the register file.
        if (dec.wsel == '0)
            dec.regwrite = 1'b0;
    end

    always_comb begin
        hazard_stall = (HAZARD_EN != 0) && ihit && ex_dren && (ex_wsel != '0) &&
                       ((ex_wsel == rs_f) || (uses_rt && (ex_wsel == rt_f))) &&
                       !flush && !halt_q;
    end

    // Bubbles clear every field; only reset releases the sticky halt flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            id_q   <= '0;
            halt_q <= 1'b0;
        end else if (flush || halt_q || hazard_stall || !ihit) begin
            id_q   <= '0;
        end else begin
            id_q   <= dec;
            halt_q <= is_halt;
        end
    end

    assign id_valid    = id_q.valid;
    assign id_rs       = id_q.rs;
    assign id_rt       = id_q.rt;
    assign id_wsel     = id_q.wsel;
    assign id_shamt    = id_q.shamt;
    assign id_imm      = id_q.imm;
    assign id_jaddr    = id_q.jaddr;
    assign id_npc      = id_q.npc;
    assign id_aluop    = id_q.aluop;
    assign id_alusrc   = id_q.alusrc;
    assign id_pcsrc    = id_q.pcsrc;
    assign id_regsrc   = id_q.regsrc;
    assign id_regwrite = id_q.regwrite;
    assign id_dren     = id_q.dren;
    assign id_dwen     = id_q.dwen;
    assign id_halt     = halt_q;

endmodule
